rob_writeback_arbiter: RTL and testbench
========================================

Name: rob_writeback_arbiter

Overview:
- Shares the ROB result-writeback path among three producers: ALU1, ALU2 and LSB load.
- Each producer pushes {tag, value} into its own small FIFO.
- A round-robin arbiter drains one entry per cycle onto a registered common data bus (CDB), which feeds the ROB writeback port and RS/LSB wakeup.
- The block flushes on mispredict clear and stalls when rdy_in is low.

Parameters:
ROB_WIDTH, 4, width of ROB tag
QUEUE_WIDTH, 1, log2 of per-producer FIFO depth (default depth 2)
QUEUE_SIZE, 2**QUEUE_WIDTH, per-producer FIFO depth

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global enable; block frozen when low
clear_signal  input  1  mispredict flush from ROB
alu1_valid  input  1  ALU1 result offered
alu1_value  input  32  ALU1 result
alu1_tag  input  ROB_WIDTH  ALU1 destination ROB tag
alu1_ready  output  1  ALU1 FIFO can accept
alu2_valid / alu2_value / alu2_tag / alu2_ready  as ALU1 (1/32/ROB_WIDTH/1)
lsb_valid / lsb_value / lsb_tag / lsb_ready  as ALU1, for load results
cdb_valid  output  1  one-cycle pulse per broadcast result
cdb_value  output  32  broadcast value
cdb_tag  output  ROB_WIDTH  broadcast ROB tag
cdb_src  output  2  granted source: 0=ALU1, 1=ALU2, 2=LSB

Behaviour:
- Reset (async, rst_in=1):
  - all FIFOs empty (count=0, pointers=0); rr_ptr=0
  - cdb_valid=0, cdb_value=0, cdb_tag=0, cdb_src=0
  - x_ready=1 once reset is released
- x_ready = (count_x != QUEUE_SIZE); purely from registered count; no dependence on same-cycle pop.
- Push: on posedge, if rdy_in & ~clear_signal & x_valid & x_ready, write {tag, value} at rear and increment rear.
- Arbitration:
  - Requests are the non-empty FIFOs, using registered count, so an entry pushed at edge N is eligible at edge N+1.
  - Search order starts at rr_ptr, then rr_ptr+1, rr_ptr+2 (mod 3).
  - The first non-empty FIFO wins: its front is popped into the cdb_* registers, cdb_valid<=1, cdb_src<=winner, rr_ptr<=(winner+1) mod 3.
  - No request: cdb_valid<=0; value/tag/src hold.
- Latency: minimum 2 edges from accepted push to cdb_valid high (push at edge N, broadcast after edge N+1).
- Same-cycle push and pop on one FIFO are both performed; count unchanged.
- Wrap-around: pointers are QUEUE_WIDTH bits and wrap naturally; count is QUEUE_WIDTH+1 bits.
- Throughput: one broadcast per cycle. Each producer is guaranteed 1 grant per 3 cycles while non-empty.
- clear_signal=1 with rdy_in=1:
  - all FIFOs emptied; rr_ptr<=0; cdb_valid<=0
  - any push in that cycle is discarded
  - takes precedence over push and pop
- rdy_in=0: no state changes at all, including FIFOs, rr_ptr and cdb_* (cdb_valid holds its level). The ROB gates on rdy_in itself.
- Reset mid-operation: asynchronous return to reset state; in-flight entries are lost.
- Values are passed through unmodified. No tag-range checking; the producer owns tag validity.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: on edge N, if no FIFO is non-empty (so no FIFO request exists) and exactly one producer pushes, that producer's {tag, value} is loaded directly into cdb_* without entering its FIFO.
  - Latency is 1 edge; rr_ptr updates as a normal grant.
  - With two or more simultaneous pushes, the rr-priority winner is bypassed and the others enqueue.
- Undefined: all results pass through the FIFOs (2-edge minimum latency).

Test Plan:
- Reset: assert rst_in mid-stream with 2 entries queued -> all x_ready=1, cdb_valid=0 immediately (no clock edge); no later broadcast of the flushed entries.
- Single result: alu1 tag=3 value=0x1234 pushed at edge N -> cdb_valid=1, tag=3, value=0x1234, src=0 after edge N+1 only (after edge N when WB_ARB_BYPASS_EN).
- Contention: all three push at edge N with tags 1/2/3, rr_ptr=0 -> broadcasts in order src 0,1,2 on three consecutive cycles. Repeat with rr_ptr=1 -> order 1,2,0.
- Backpressure: lsb pushes 3 with no drain opportunity (ALU1/ALU2 kept busy, QUEUE_SIZE=2) -> lsb_ready=0 after 2 accepts. Third result held by the producer and broadcast later; no loss, no duplicate.
- Flush: 2 entries queued, clear_signal=1 with a concurrent alu2 push -> next cycle cdb_valid=0, all ready=1, no broadcast of any of the 3.
- Stall: rdy_in=0 for 5 cycles with cdb_valid=1 and entries queued -> cdb_* and x_ready constant. The sequence resumes unchanged when rdy_in=1.

Source files
------------

// File: rtl/rob_writeback_arbiter_if.sv
// rob_writeback_arbiter_if: producer pushes (ALU1/ALU2/LSB) and the common data bus.
interface rob_writeback_arbiter_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 alu1_valid;
    logic [31:0]          alu1_value;
    logic [ROB_WIDTH-1:0] alu1_tag;
    logic                 alu1_ready;
    logic                 alu2_valid;
    logic [31:0]          alu2_value;
    logic [ROB_WIDTH-1:0] alu2_tag;
    logic                 alu2_ready;
    logic                 lsb_valid;
    logic [31:0]          lsb_value;
    logic [ROB_WIDTH-1:0] lsb_tag;
    logic                 lsb_ready;
    logic                 cdb_valid;
    logic [31:0]          cdb_value;
    logic [ROB_WIDTH-1:0] cdb_tag;
    logic [1:0]           cdb_src;
    modport master (
        output alu1_valid, alu1_value, alu1_tag, alu2_valid, alu2_value, alu2_tag,
               lsb_valid, lsb_value, lsb_tag,
        input  alu1_ready, alu2_ready, lsb_ready, cdb_valid, cdb_value, cdb_tag, cdb_src
    );
    modport slave (
        input  alu1_valid, alu1_value, alu1_tag, alu2_valid, alu2_value, alu2_tag,
               lsb_valid, lsb_value, lsb_tag,
        output alu1_ready, alu2_ready, lsb_ready, cdb_valid, cdb_value, cdb_tag, cdb_src
    );
endinterface

// File: rtl/rob_writeback_arbiter.sv
// rob_writeback_arbiter: per-producer FIFOs drained round-robin onto a registered CDB.
// Define WB_ARB_BYPASS_EN to send a push straight to the CDB when every FIFO is empty.
module rob_writeback_arbiter #(
    parameter int ROB_WIDTH   = 4,
    parameter int QUEUE_WIDTH = 1,
    parameter int QUEUE_SIZE  = 2 ** QUEUE_WIDTH
) (
    input logic                    clk_in,
    input logic                    rst_in,
    input logic                    rdy_in,
    input logic                    clear_signal,
    rob_writeback_arbiter_if.slave bus
);
    localparam int EW = ROB_WIDTH + 32;
    typedef logic [QUEUE_WIDTH:0]   cnt_t;
    typedef logic [QUEUE_WIDTH-1:0] ptr_t;

    logic [2:0]    in_valid, ready, req, cand, push_acc, do_push, do_pop;
    logic [EW-1:0] in_ent [3];
    logic [EW-1:0] mem_q [3][QUEUE_SIZE];
    ptr_t          front_q [3], front_d [3], rear_q [3], rear_d [3];
    cnt_t          count_q [3], count_d [3];
    logic [1:0]    rr_q, rr_d, win, idx, cdb_src_q, cdb_src_d;
    logic          active, found, byp, cdb_valid_q, cdb_valid_d;
    logic [EW-1:0] win_ent, cdb_ent_q, cdb_ent_d;

    assign active    = rdy_in & ~clear_signal;
    assign in_valid  = {bus.lsb_valid, bus.alu2_valid, bus.alu1_valid};
    assign in_ent[0] = {bus.alu1_tag, bus.alu1_value};
    assign in_ent[1] = {bus.alu2_tag, bus.alu2_value};
    assign in_ent[2] = {bus.lsb_tag, bus.lsb_value};
    assign {bus.lsb_ready, bus.alu2_ready, bus.alu1_ready} = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign {bus.cdb_tag, bus.cdb_value} = cdb_ent_q;
    assign bus.cdb_src = cdb_src_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ready[i] = count_q[i] != cnt_t'(QUEUE_SIZE);
            req[i]   = count_q[i] != '0;
        end
        push_acc = in_valid & ready & {3{active}};
    end

`ifdef WB_ARB_BYPASS_EN
    assign byp = ~|req & |push_acc;
`else
    assign byp = 1'b0;
`endif

    // In bypass the same rr search picks among this cycle's pushes instead of FIFO fronts.
    always_comb begin
        cand  = byp ? push_acc : req;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(rr_q) + k) % 3);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_ent = byp ? in_ent[win] : mem_q[win][front_q[win]];
        do_pop  = (found && !byp && active) ? (3'b001 << win) : 3'b000;
        do_push = push_acc & ~(byp ? (3'b001 << win) : 3'b000);
    end

    always_comb begin
        rr_d        = rr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_ent_d   = cdb_ent_q;
        cdb_src_d   = cdb_src_q;
        for (int i = 0; i < 3; i++) begin
            front_d[i] = front_q[i];
            rear_d[i]  = rear_q[i];
            count_d[i] = count_q[i];
        end
        if (rdy_in && clear_signal) begin
            for (int i = 0; i < 3; i++) begin
                front_d[i] = '0;
                rear_d[i]  = '0;
                count_d[i] = '0;
            end
            rr_d        = '0;
            cdb_valid_d = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < 3; i++) begin
                front_d[i] = front_q[i] + ptr_t'(do_pop[i]);
                rear_d[i]  = rear_q[i] + ptr_t'(do_push[i]);
                count_d[i] = count_q[i] + cnt_t'(do_push[i]) - cnt_t'(do_pop[i]);
            end
            cdb_valid_d = found;
            if (found) begin
                cdb_ent_d = win_ent;
                cdb_src_d = win;
                rr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 3; i++) begin
                front_q[i] <= '0;
                rear_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_ent_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                front_q[i] <= front_d[i];
                rear_q[i]  <= rear_d[i];
                count_q[i] <= count_d[i];
            end
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_ent_q   <= cdb_ent_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 3; i++)
            if (do_push[i]) mem_q[i][rear_q[i]] <= in_ent[i];
    end
endmodule

// File: tb/tb_rob_writeback_arbiter.sv
// tb_rob_writeback_arbiter: directed scenario tasks for the ROB writeback arbiter.
module tb_rob_writeback_arbiter;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clear_signal;
    int   checks = 0;
    int   errors = 0;

    rob_writeback_arbiter_if #(.ROB_WIDTH(4)) bus ();
    rob_writeback_arbiter #(.ROB_WIDTH(4), .QUEUE_WIDTH(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal), .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] val(input logic [3:0] t);
        return 32'hC0DE_0000 | 32'(t);
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle;
        bus.alu1_valid = 0; bus.alu1_tag = '0; bus.alu1_value = '0;
        bus.alu2_valid = 0; bus.alu2_tag = '0; bus.alu2_value = '0;
        bus.lsb_valid  = 0; bus.lsb_tag  = '0; bus.lsb_value  = '0;
    endtask

    task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        bus.alu1_valid = 1; bus.alu1_tag = a; bus.alu1_value = val(a);
        bus.alu2_valid = 1; bus.alu2_tag = b; bus.alu2_value = val(b);
        bus.lsb_valid  = 1; bus.lsb_tag  = c; bus.lsb_value  = val(c);
    endtask

    task automatic test_reset;
        rst_in = 1; rdy_in = 1; clear_signal = 0; idle();
        #1;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.cdb_valid); end
        checks++; if (bus.cdb_value !== 32'h0) begin errors++; $display("FAIL reset_value got %h want 0", bus.cdb_value); end
        checks++; if (bus.cdb_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h want 0", bus.cdb_tag); end
        checks++; if (bus.cdb_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", bus.cdb_src); end
        checks++; if ({bus.lsb_ready, bus.alu2_ready, bus.alu1_ready} !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", {bus.lsb_ready, bus.alu2_ready, bus.alu1_ready}); end
        tick; rst_in = 0; tick;
        push3(4'd5, 4'd6, 4'd7); tick; idle();
        rst_in = 1;
        #1;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid got %b want 0", bus.cdb_valid); end
        checks++; if ({bus.lsb_ready, bus.alu2_ready, bus.alu1_ready} !== 3'b111) begin errors++; $display("FAIL reset_async_ready got %b want 111", {bus.lsb_ready, bus.alu2_ready, bus.alu1_ready}); end
        tick; rst_in = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_stale cycle %0d got valid %b tag %h want valid 0", i, bus.cdb_valid, bus.cdb_tag); end
        end
    endtask

    task automatic test_single;
        bus.alu1_valid = 1; bus.alu1_tag = 4'd3; bus.alu1_value = 32'h1234;
        tick; idle();
`ifndef WB_ARB_BYPASS_EN
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_early got valid %b want 0", bus.cdb_valid); end
        tick;
`endif
        checks++; if (bus.cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.cdb_valid); end
        checks++; if (bus.cdb_tag !== 4'd3) begin errors++; $display("FAIL single_tag got %h want 3", bus.cdb_tag); end
        checks++; if (bus.cdb_value !== 32'h1234) begin errors++; $display("FAIL single_value got %h want 1234", bus.cdb_value); end
        checks++; if (bus.cdb_src !== 2'd0) begin errors++; $display("FAIL single_src got %0d want 0", bus.cdb_src); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_contention;
        logic [1:0] es;
        logic [3:0] et;
        clear_signal = 1; tick; clear_signal = 0;
        for (int r = 0; r < 2; r++) begin
            push3(4'd1, 4'd2, 4'd3); tick; idle();
`ifndef WB_ARB_BYPASS_EN
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_early rr%0d got valid %b want 0", r, bus.cdb_valid); end
            tick;
`endif
            for (int k = 0; k < 3; k++) begin
                es = 2'((r + k) % 3);
                et = 4'(es) + 4'd1;
                checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== es || bus.cdb_tag !== et || bus.cdb_value !== val(et))
                    begin errors++; $display("FAIL cont rr%0d slot %0d got v%b src%0d tag%h val%h want v1 src%0d tag%h val%h", r, k, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_value, es, et, val(et)); end
                tick;
            end
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_end rr%0d got valid %b want 0", r, bus.cdb_valid); end
            if (r == 0) begin
                bus.alu1_valid = 1; bus.alu1_tag = 4'd9; bus.alu1_value = val(4'd9);
                tick; idle(); tick; tick;
            end
        end
    endtask

    task automatic test_backpressure;
        int ai = 0, bi = 0, li = 0, nb = 0;
        int seen [16];
        logic acc_a, acc_b, acc_l;
        logic [3:0] tags [7] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
        foreach (seen[t]) seen[t] = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.alu1_valid = ai < 2; bus.alu1_tag = 4'(1 + ai); bus.alu1_value = val(4'(1 + ai));
            bus.alu2_valid = bi < 2; bus.alu2_tag = 4'(4 + bi); bus.alu2_value = val(4'(4 + bi));
            bus.lsb_valid  = li < 3; bus.lsb_tag  = 4'(8 + li); bus.lsb_value  = val(4'(8 + li));
            acc_a = bus.alu1_valid & bus.alu1_ready;
            acc_b = bus.alu2_valid & bus.alu2_ready;
            acc_l = bus.lsb_valid & bus.lsb_ready;
            tick;
            ai += int'(acc_a); bi += int'(acc_b); li += int'(acc_l);
            if (bus.cdb_valid) begin
                seen[bus.cdb_tag]++;
                nb++;
                checks++; if (bus.cdb_value !== val(bus.cdb_tag)) begin errors++; $display("FAIL bp_value tag %h got %h want %h", bus.cdb_tag, bus.cdb_value, val(bus.cdb_tag)); end
            end
`ifndef WB_ARB_BYPASS_EN
            if (cyc == 1) begin
                checks++; if (bus.lsb_ready !== 1'b0 || li != 2) begin errors++; $display("FAIL bp_full got ready %b accepts %0d want ready 0 accepts 2", bus.lsb_ready, li); end
            end
`endif
        end
        idle();
        checks++; if (ai != 2 || bi != 2 || li != 3) begin errors++; $display("FAIL bp_accepted got %0d/%0d/%0d want 2/2/3", ai, bi, li); end
        checks++; if (nb != 7) begin errors++; $display("FAIL bp_broadcasts got %0d want 7", nb); end
        foreach (tags[j]) begin
            checks++; if (seen[tags[j]] != 1) begin errors++; $display("FAIL bp_once tag %h seen %0d want 1", tags[j], seen[tags[j]]); end
        end
    endtask

    task automatic test_flush;
        bus.alu1_valid = 1; bus.alu1_tag = 4'd11; bus.alu1_value = val(4'd11);
        bus.lsb_valid  = 1; bus.lsb_tag  = 4'd12; bus.lsb_value  = val(4'd12);
        tick; idle();
        clear_signal = 1;
        bus.alu2_valid = 1; bus.alu2_tag = 4'd13; bus.alu2_value = val(4'd13);
        tick; clear_signal = 0; idle();
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.cdb_valid); end
        checks++; if ({bus.lsb_ready, bus.alu2_ready, bus.alu1_ready} !== 3'b111) begin errors++; $display("FAIL flush_ready got %b want 111", {bus.lsb_ready, bus.alu2_ready, bus.alu1_ready}); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d got tag %h want no broadcast", i, bus.cdb_tag); end
        end
        bus.alu2_valid = 1; bus.alu2_tag = 4'd14; bus.alu2_value = val(4'd14);
        bus.lsb_valid  = 1; bus.lsb_tag  = 4'd15; bus.lsb_value  = val(4'd15);
        tick; idle();
`ifndef WB_ARB_BYPASS_EN
        tick;
`endif
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_tag !== 4'd14) begin errors++; $display("FAIL flush_rr_first got v%b src%0d tag%h want v1 src1 tag e", bus.cdb_valid, bus.cdb_src, bus.cdb_tag); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2 || bus.cdb_tag !== 4'd15) begin errors++; $display("FAIL flush_rr_second got v%b src%0d tag%h want v1 src2 tag f", bus.cdb_valid, bus.cdb_src, bus.cdb_tag); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_rr_end got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_stall;
        push3(4'd1, 4'd2, 4'd3); tick; idle();
`ifndef WB_ARB_BYPASS_EN
        tick;
`endif
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_tag !== 4'd1) begin errors++; $display("FAIL stall_pre got v%b src%0d tag%h want v1 src0 tag1", bus.cdb_valid, bus.cdb_src, bus.cdb_tag); end
        rdy_in = 0;
        bus.alu1_valid = 1; bus.alu1_tag = 4'd7; bus.alu1_value = val(4'd7);
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_tag !== 4'd1 || bus.cdb_value !== val(4'd1))
                begin errors++; $display("FAIL stall_hold cycle %0d got v%b src%0d tag%h val%h want v1 src0 tag1 val%h", i, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_value, val(4'd1)); end
            checks++; if ({bus.lsb_ready, bus.alu2_ready, bus.alu1_ready} !== 3'b111) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 111", i, {bus.lsb_ready, bus.alu2_ready, bus.alu1_ready}); end
        end
        idle(); rdy_in = 1;
        tick;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_tag !== 4'd2) begin errors++; $display("FAIL stall_resume1 got v%b src%0d tag%h want v1 src1 tag2", bus.cdb_valid, bus.cdb_src, bus.cdb_tag); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2 || bus.cdb_tag !== 4'd3) begin errors++; $display("FAIL stall_resume2 got v%b src%0d tag%h want v1 src2 tag3", bus.cdb_valid, bus.cdb_src, bus.cdb_tag); end
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL stall_drop cycle %0d got tag %h want no broadcast", i, bus.cdb_tag); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
